fifo_ptr_ctrl: RTL

//  Parametrised pointer/flag controller for a circular buffer built on an external

---
 rtl/fifo_ptr_ctrl.sv | 111 +++++++++++
 1 files changed

// File: rtl/fifo_ptr_ctrl.sv
// fifo_ptr_ctrl: pointer and flag controller for a circular buffer on an external
// synchronous dual-port RAM. There is no data path here; only addresses, enables and status.
// Ports:
//   clk, rst          clock and asynchronous active-high reset
//   clr               synchronous clear of pointers and error flags (beats push/pop)
//   push, pop         write / read requests (strobes, or levels when EDGE_DET=1)
//   wr_en, wr_addr    RAM write enable and address (combinational, same cycle as request)
//   rd_en, rd_addr    RAM read enable and address (combinational, same cycle as request)
//   count             entries stored, 0..DEPTH
//   full, empty       count==DEPTH / count==0
//   almost_full       count >= AF_LEVEL
//   almost_empty      count <= AE_LEVEL
//   overflow          sticky: a push was rejected
//   underflow         sticky: a pop was rejected
module fifo_ptr_ctrl #(
  parameter int unsigned ADDR_W   = 3,
  parameter int unsigned AF_LEVEL = 6,
  parameter int unsigned AE_LEVEL = 2,
  parameter int unsigned EDGE_DET = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              push,
  input  logic              pop,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic              overflow,
  output logic              underflow
);

  localparam int unsigned PTR_W = ADDR_W + 1;
  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic             push_dly_q, push_dly_d;
  logic             pop_dly_q, pop_dly_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             push_req, pop_req;

  // Request qualification: optional rising-edge detect so a held key is one request.
  assign push_req = (EDGE_DET != 0) ? (push & ~push_dly_q) : push;
  assign pop_req  = (EDGE_DET != 0) ? (pop  & ~pop_dly_q)  : pop;

  // Status decode from the registered pointers; MSB is the wrap bit.
  assign count        = wr_ptr_q - rd_ptr_q;
  assign empty        = (wr_ptr_q == rd_ptr_q);
  assign full         = (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]) &&
                        (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);
  assign almost_full  = (count >= PTR_W'(AF_LEVEL));
  assign almost_empty = (count <= PTR_W'(AE_LEVEL));

  // Same-cycle acceptance; full/empty gating keeps read and write off the same address.
  assign wr_en   = push_req & ~full  & ~clr;
  assign rd_en   = pop_req  & ~empty & ~clr;
  assign wr_addr = wr_ptr_q[ADDR_W-1:0];
  assign rd_addr = rd_ptr_q[ADDR_W-1:0];

  assign overflow  = ovf_q;
  assign underflow = unf_q;

  // Next-state: pointer advance, sticky errors, edge-detect history.
  always_comb begin
    wr_ptr_d   = wr_ptr_q + PTR_W'(wr_en);
    rd_ptr_d   = rd_ptr_q + PTR_W'(rd_en);
    ovf_d      = ovf_q | (push_req & full  & ~clr);
    unf_d      = unf_q | (pop_req  & empty & ~clr);
    push_dly_d = push;
    pop_dly_d  = pop;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      ovf_d    = 1'b0;
      unf_d    = 1'b0;
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      push_dly_q <= 1'b0;
      pop_dly_q  <= 1'b0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      push_dly_q <= push_dly_d;
      pop_dly_q  <= pop_dly_d;
      ovf_q      <= ovf_d;
      unf_q      <= unf_d;
    end
  end

  // Sanity: DEPTH must fit the count width used for the level compares.
  if (DEPTH > (1 << 10)) begin : g_depth_chk
    $error("fifo_ptr_ctrl: ADDR_W out of range");
  end

endmodule
